// File: rtl/edge_row_scanner.sv
// edge_row_scanner: [1,0,-1] gradient edge detector that records edge x/polarity on N_ROWS programmable rows per frame
//   in : clk, reset, sop/eop/in_valid/x/y/grey pixel stream, row_y, threshold, min_gap, x_lo/x_hi window, rd_row/rd_idx
//   out: edge_flag/edge_pol per pixel, results_valid commit pulse, rd_x/rd_pol/rd_count shadow read, overflow per row
module edge_row_scanner #(
    parameter int XW        = 11,
    parameter int N_ROWS    = 4,
    parameter int MAX_EDGES = 30,
    parameter int IW        = $clog2(MAX_EDGES),
    parameter int RW        = (N_ROWS > 1) ? $clog2(N_ROWS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sop,
    input  logic                 eop,
    input  logic                 in_valid,
    input  logic [XW-1:0]        x,
    input  logic [XW-1:0]        y,
    input  logic [7:0]           grey,
    input  logic [N_ROWS*XW-1:0] row_y,
    input  logic [7:0]           threshold,
    input  logic [XW-1:0]        min_gap,
    input  logic [XW-1:0]        x_lo,
    input  logic [XW-1:0]        x_hi,
    output logic                 edge_flag,
    output logic                 edge_pol,
    output logic                 results_valid,
    input  logic [RW-1:0]        rd_row,
    input  logic [IW-1:0]        rd_idx,
    output logic [XW-1:0]        rd_x,
    output logic                 rd_pol,
    output logic [IW:0]          rd_count,
    output logic [N_ROWS-1:0]    overflow
);
    localparam logic [IW:0] MAX_C = (IW+1)'(MAX_EDGES);
    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
    state_t state_q, state_d;
    logic [7:0] g1_q, g1_d, g2_q, g2_d;
    logic edge_flag_q, edge_flag_d, edge_pol_q, edge_pol_d;
    logic [XW-1:0] cap_x_q [N_ROWS][MAX_EDGES];
    logic [XW-1:0] cap_x_d [N_ROWS][MAX_EDGES];
    logic [XW-1:0] sh_x_q [N_ROWS][MAX_EDGES];
    logic [XW-1:0] sh_x_d [N_ROWS][MAX_EDGES];
    logic [MAX_EDGES-1:0] cap_pol_q [N_ROWS];
    logic [MAX_EDGES-1:0] cap_pol_d [N_ROWS];
    logic [MAX_EDGES-1:0] sh_pol_q [N_ROWS];
    logic [MAX_EDGES-1:0] sh_pol_d [N_ROWS];
    logic [IW:0] cnt_q [N_ROWS];
    logic [IW:0] cnt_d [N_ROWS];
    logic [IW:0] sh_cnt_q [N_ROWS];
    logic [IW:0] sh_cnt_d [N_ROWS];
    logic [XW-1:0] last_q [N_ROWS];
    logic [XW-1:0] last_d [N_ROWS];
    logic [N_ROWS-1:0] ovf_q, ovf_d, sh_ovf_q, sh_ovf_d;
    logic [XW-1:0] rd_x_q, rd_x_d;
    logic rd_pol_q, rd_pol_d;
    logic [IW:0] rd_count_q, rd_count_d;
    logic signed [8:0] conv;
    logic [8:0] mag;
    logic is_edge, pol, in_win, rd_ok;
    logic [XW-1:0] x_c;

    assign conv    = $signed({1'b0, grey}) - $signed({1'b0, g2_q});
    assign mag     = conv[8] ? -conv : conv;
    assign is_edge = x >= XW'(2) && mag > {1'b0, threshold};
    assign pol     = !conv[8] && conv != 9'sd0;
    assign x_c     = x - XW'(1);
    assign in_win  = x_c > x_lo && x_c < x_hi;
    assign rd_ok   = 32'(rd_row) < N_ROWS;

    always_comb begin
        state_d     = state_q;
        g1_d        = g1_q;
        g2_d        = g2_q;
        cap_x_d     = cap_x_q;
        cap_pol_d   = cap_pol_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        ovf_d       = ovf_q;
        sh_x_d      = sh_x_q;
        sh_pol_d    = sh_pol_q;
        sh_cnt_d    = sh_cnt_q;
        sh_ovf_d    = sh_ovf_q;
        edge_flag_d = in_valid && is_edge;
        edge_pol_d  = in_valid && is_edge && pol;
        // g2 restarts at 0 on each line so x=2 sees grey[0] as its left neighbour
        if (in_valid) begin
            g1_d = grey;
            g2_d = (x == '0) ? '0 : g1_q;
        end
        if (in_valid && sop) begin
            state_d   = SCAN;
            cap_x_d   = '{default: '0};
            cap_pol_d = '{default: '0};
            cnt_d     = '{default: '0};
            last_d    = '{default: '0};
            ovf_d     = '0;
        end else if (state_q == SCAN && in_valid) begin
            state_d = eop ? COMMIT : SCAN;
            for (int r = 0; r < N_ROWS; r++)
                if (is_edge && in_win && y == row_y[r*XW +: XW]) begin
                    last_d[r] = x_c;
                    if (cnt_q[r] == '0 || x_c - last_q[r] > min_gap) begin
                        if (cnt_q[r] == MAX_C) ovf_d[r] = 1'b1;
                        else begin
                            cap_x_d[r][cnt_q[r][IW-1:0]]   = x_c;
                            cap_pol_d[r][cnt_q[r][IW-1:0]] = pol;
                            cnt_d[r] = cnt_q[r] + 1'b1;
                        end
                    end
                end
        end else if (state_q == COMMIT) begin
            state_d  = IDLE;
            sh_x_d   = cap_x_q;
            sh_pol_d = cap_pol_q;
            sh_cnt_d = cnt_q;
            sh_ovf_d = ovf_q;
        end
        // reads use the post-commit bank so a colliding read returns the new frame
        rd_count_d = rd_ok ? sh_cnt_d[rd_row] : '0;
        rd_x_d     = (rd_ok && {1'b0, rd_idx} < sh_cnt_d[rd_row]) ? sh_x_d[rd_row][rd_idx] : '0;
        rd_pol_d   = rd_ok && {1'b0, rd_idx} < sh_cnt_d[rd_row] && sh_pol_d[rd_row][rd_idx];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            g1_q        <= '0;
            g2_q        <= '0;
            edge_flag_q <= 1'b0;
            edge_pol_q  <= 1'b0;
            cap_x_q     <= '{default: '0};
            cap_pol_q   <= '{default: '0};
            cnt_q       <= '{default: '0};
            last_q      <= '{default: '0};
            ovf_q       <= '0;
            sh_x_q      <= '{default: '0};
            sh_pol_q    <= '{default: '0};
            sh_cnt_q    <= '{default: '0};
            sh_ovf_q    <= '0;
            rd_x_q      <= '0;
            rd_pol_q    <= 1'b0;
            rd_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            g1_q        <= g1_d;
            g2_q        <= g2_d;
            edge_flag_q <= edge_flag_d;
            edge_pol_q  <= edge_pol_d;
            cap_x_q     <= cap_x_d;
            cap_pol_q   <= cap_pol_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            ovf_q       <= ovf_d;
            sh_x_q      <= sh_x_d;
            sh_pol_q    <= sh_pol_d;
            sh_cnt_q    <= sh_cnt_d;
            sh_ovf_q    <= sh_ovf_d;
            rd_x_q      <= rd_x_d;
            rd_pol_q    <= rd_pol_d;
            rd_count_q  <= rd_count_d;
        end
    end

    assign edge_flag     = edge_flag_q;
    assign edge_pol      = edge_pol_q;
    assign results_valid = state_q == COMMIT;
    assign rd_x          = rd_x_q;
    assign rd_pol        = rd_pol_q;
    assign rd_count      = rd_count_q;
    assign overflow      = sh_ovf_q;
endmodule
